// File: rtl/eth_phy_link_ctrl_pkg.sv
// Shared types and widths for the 10G PHY rx link bring-up controller.
package eth_phy_link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_PRBS_TEST   = 3'd3,
    ST_WAIT_STABLE = 3'd4,
    ST_UP          = 3'd5,
    ST_FAIL        = 3'd6
  } link_state_t;

  localparam int unsigned PRBS_ERR_W = 16;
  localparam int unsigned ERR_CNT_W  = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_phy_link_ctrl_timer.sv
// Loadable down-counter shared by all timed phases; holds at zero.
module link_ctrl_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/eth_phy_link_ctrl.sv
// PHY rx link bring-up / supervision FSM with retry limit.
// Optional PRBS31 self-test phase enabled by defining LINK_CTRL_PRBS_EN.
module eth_phy_link_ctrl
  import eth_phy_link_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned PRBS_CYCLES   = 1024,
  parameter int unsigned ERR_THRESH    = 16,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               rx_block_lock,
  input  logic                               rx_high_ber,
  input  logic                               rx_status,
  input  logic [ERR_CNT_W-1:0]               rx_error_count,
  output logic                               phy_rx_rst,
  output logic                               cfg_tx_prbs31_enable,
  output logic                               cfg_rx_prbs31_enable,
  output logic                               link_up,
  output logic                               link_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [PRBS_ERR_W-1:0]              prbs_err_total,
  output logic [2:0]                         state
);

  localparam int unsigned RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMR_MAX = max_u(max_u(RESET_HOLD, LOCK_TIMEOUT),
                                          max_u(PRBS_CYCLES, STABLE_CYCLES));
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  link_state_t             state_q, state_d;
  logic [RC_W-1:0]         retry_q, retry_d;
  logic [PRBS_ERR_W-1:0]   total_q, total_d;
  logic                    prbs_en_q;
  logic                    tmr_load, tmr_zero, do_retry, link_good;
  logic [TMR_W-1:0]        tmr_val, tmr_value_unused;

  assign link_good = rx_block_lock & ~rx_high_ber & rx_status;

`ifdef LINK_CTRL_PRBS_EN
  logic [PRBS_ERR_W:0] sum_ext;
  assign sum_ext = {1'b0, total_q} + (PRBS_ERR_W+1)'(rx_error_count);
`endif

  link_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .value      (tmr_value_unused),
    .zero       (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    total_d  = total_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    do_retry = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      retry_d  = '0;
      total_d  = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_RESET;
          retry_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RESET_HOLD - 1);
        end
        ST_RESET: begin
          if (tmr_zero) begin
            state_d  = ST_WAIT_LOCK;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCK_TIMEOUT - 1);
          end
        end
        ST_WAIT_LOCK: begin
          if (rx_block_lock) begin
            tmr_load = 1'b1;
`ifdef LINK_CTRL_PRBS_EN
            state_d  = ST_PRBS_TEST;
            total_d  = '0;
            tmr_val  = TMR_W'(PRBS_CYCLES - 1);
`else
            state_d  = ST_WAIT_STABLE;
            tmr_val  = TMR_W'(STABLE_CYCLES - 1);
`endif
          end else if (tmr_zero) begin
            do_retry = 1'b1;
          end
        end
`ifdef LINK_CTRL_PRBS_EN
        ST_PRBS_TEST: begin
          // Final cycle's count is folded in before the threshold decision.
          total_d = sum_ext[PRBS_ERR_W] ? '1 : sum_ext[PRBS_ERR_W-1:0];
          if (!rx_block_lock) begin
            do_retry = 1'b1;
          end else if (tmr_zero) begin
            if (32'(total_d) >= ERR_THRESH) begin
              do_retry = 1'b1;
            end else begin
              state_d  = ST_WAIT_STABLE;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(STABLE_CYCLES - 1);
            end
          end
        end
`endif
        ST_WAIT_STABLE: begin
          if (!link_good) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(STABLE_CYCLES - 1);
          end else if (tmr_zero) begin
            state_d = ST_UP;
          end
        end
        ST_UP: begin
          if (rx_high_ber || !rx_block_lock) begin
            do_retry = 1'b1;
          end
        end
        ST_FAIL: ;
        default: state_d = ST_IDLE;
      endcase

      if (do_retry) begin
        if (retry_q == RC_W'(MAX_RETRIES)) begin
          state_d = ST_FAIL;
        end else begin
          retry_d  = retry_q + RC_W'(1);
          state_d  = ST_RESET;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(RESET_HOLD - 1);
        end
      end
    end
  end

  // Outputs are registered from the next state so they move with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      retry_q    <= '0;
      total_q    <= '0;
      prbs_en_q  <= 1'b0;
      phy_rx_rst <= 1'b1;
      link_up    <= 1'b0;
      link_fail  <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      total_q    <= total_d;
      prbs_en_q  <= (state_d == ST_PRBS_TEST);
      phy_rx_rst <= (state_d inside {ST_IDLE, ST_RESET, ST_FAIL});
      link_up    <= (state_d == ST_UP);
      link_fail  <= (state_d == ST_FAIL);
    end
  end

  assign state       = state_q;
  assign retry_count = retry_q;

`ifdef LINK_CTRL_PRBS_EN
  assign cfg_tx_prbs31_enable = prbs_en_q;
  assign cfg_rx_prbs31_enable = prbs_en_q;
  assign prbs_err_total       = total_q;
`else
  logic unused_prbs;
  assign unused_prbs          = ^{prbs_en_q, total_q, rx_error_count, ERR_THRESH[0]};
  assign cfg_tx_prbs31_enable = 1'b0;
  assign cfg_rx_prbs31_enable = 1'b0;
  assign prbs_err_total       = '0;
`endif

endmodule

// File: tb/tb_eth_phy_link_ctrl.sv
// Randomized self-checking bench for eth_phy_link_ctrl against a phase-level reference model.
module tb_eth_phy_link_ctrl;

  localparam int RESET_HOLD    = 16;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int PRBS_CYCLES   = 1024;
  localparam int ERR_THRESH    = 16;
  localparam int STABLE_CYCLES = 64;
  localparam int MAX_RETRIES   = 3;

  localparam int S_IDLE = 0, S_RESET = 1, S_WAIT_LOCK = 2, S_PRBS = 3,
                 S_WS = 4, S_UP = 5, S_FAIL = 6;
`ifdef LINK_CTRL_PRBS_EN
  localparam int EXP_UP = RESET_HOLD + 1 + PRBS_CYCLES + STABLE_CYCLES;
  localparam int MID    = S_PRBS;
`else
  localparam int EXP_UP = RESET_HOLD + 1 + STABLE_CYCLES;
  localparam int MID    = S_WS;
`endif
  localparam logic [25:0] RST_BUNDLE = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0};

  logic        clk_tb = 1'b0;
  logic        rx_rst_tb;
  logic        enable, rx_block_lock, rx_high_ber, rx_status;
  logic [6:0]  rx_error_count;
  logic        phy_rx_rst, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable;
  logic        link_up, link_fail;
  logic [1:0]  retry_count;
  logic [15:0] prbs_err_total;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_mis = 0;

  int     m_st, m_elapsed, m_run, m_retries;
  longint m_sum;

  eth_phy_link_ctrl dut (
    .clk                  (clk_tb),
    .rst_n                (rx_rst_tb),
    .enable               (enable),
    .rx_block_lock        (rx_block_lock),
    .rx_high_ber          (rx_high_ber),
    .rx_status            (rx_status),
    .rx_error_count       (rx_error_count),
    .phy_rx_rst           (phy_rx_rst),
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .link_up              (link_up),
    .link_fail            (link_fail),
    .retry_count          (retry_count),
    .prbs_err_total       (prbs_err_total),
    .state                (state)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [25:0] dut_bundle();
    return {state, link_up, link_fail, phy_rx_rst, cfg_tx_prbs31_enable,
            cfg_rx_prbs31_enable, retry_count, prbs_err_total};
  endfunction

  function automatic logic [25:0] exp_bundle();
    longint tot;
    tot = (m_sum > 65535) ? 65535 : m_sum;
    return {3'(m_st), (m_st == S_UP), (m_st == S_FAIL),
            (m_st == S_IDLE || m_st == S_RESET || m_st == S_FAIL),
            (m_st == S_PRBS), (m_st == S_PRBS), 2'(m_retries), 16'(tot)};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_elapsed = 0; m_run = 0; m_retries = 0; m_sum = 0;
  endtask

  task automatic m_go(input int s);
    m_st = s; m_elapsed = 0; m_run = 0;
  endtask

  task automatic m_retry();
    if (m_retries == MAX_RETRIES) m_go(S_FAIL);
    else begin
      m_retries++;
      m_go(S_RESET);
    end
  endtask

  // Reference: phases counted by elapsed cycles and good-run length.
  task automatic model_step();
    if (!enable) begin
      m_go(S_IDLE);
      m_retries = 0;
      m_sum = 0;
      return;
    end
    m_elapsed++;
    case (m_st)
      S_IDLE: begin m_go(S_RESET); m_retries = 0; end
      S_RESET: if (m_elapsed >= RESET_HOLD) m_go(S_WAIT_LOCK);
      S_WAIT_LOCK: begin
        if (rx_block_lock) begin
`ifdef LINK_CTRL_PRBS_EN
          m_sum = 0;
          m_go(S_PRBS);
`else
          m_go(S_WS);
`endif
        end else if (m_elapsed >= LOCK_TIMEOUT) m_retry();
      end
      S_PRBS: begin
        m_sum += longint'(rx_error_count);
        if (!rx_block_lock) m_retry();
        else if (m_elapsed >= PRBS_CYCLES) begin
          if (m_sum >= ERR_THRESH) m_retry();
          else m_go(S_WS);
        end
      end
      S_WS: begin
        if (rx_block_lock && !rx_high_ber && rx_status) m_run++;
        else m_run = 0;
        if (m_run >= STABLE_CYCLES) m_go(S_UP);
      end
      S_UP: if (rx_high_ber || !rx_block_lock) m_retry();
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk_tb);
    model_step();
    #1;
    check_val("outs", 32'(dut_bundle()), 32'(exp_bundle()));
  endtask

  task automatic drive(input logic en, input logic lk, input logic hb,
                       input logic st, input logic [6:0] err);
    enable = en; rx_block_lock = lk; rx_high_ber = hb; rx_status = st; rx_error_count = err;
  endtask

  initial begin
    int n, cnt, prev;
    bit first;
    rx_rst_tb = 1'b0;
    drive(0, 0, 0, 0, 7'd0);
    model_reset();
    #23;
    check_val("reset_state", 32'(dut_bundle()), 32'(RST_BUNDLE));
    @(negedge clk_tb) rx_rst_tb = 1'b1;
    repeat (3) tick();

    // Clean bring-up latency
    drive(1, 1, 0, 1, 7'd0);
    n = 0;
    do begin tick(); n++; end while (!link_up && n < 20000);
    check_val("bringup_latency", 32'(n - 1), 32'(EXP_UP));
    check_val("bringup_retry", 32'(retry_count), 32'd0);

    // High-BER pulse while up
    drive(1, 1, 1, 1, 7'd0);
    tick();
    drive(1, 1, 0, 1, 7'd0);
    check_val("hb_link_drop", 32'(link_up), 32'd0);
    check_val("hb_retry", 32'(retry_count), 32'd1);
    cnt = phy_rx_rst ? 1 : 0;
    for (int i = 0; i < 100 && phy_rx_rst; i++) begin
      tick();
      if (phy_rx_rst) cnt++;
    end
    check_val("hb_rst_len", 32'(cnt), 32'(RESET_HOLD));
    drive(0, 1, 0, 1, 7'd0);
    repeat (2) tick();

`ifdef LINK_CTRL_PRBS_EN
    // One error per cycle: window total then repeated failure
    drive(1, 1, 0, 1, 7'd1);
    n = 0; first = 1'b1;
    while (!link_fail && n < 20000) begin
      prev = int'(state);
      tick(); n++;
      if (first && prev == S_PRBS && int'(state) != S_PRBS) begin
        check_val("prbs_total_1", 32'(prbs_err_total), 32'(PRBS_CYCLES));
        first = 1'b0;
      end
    end
    check_val("prbs_fail_flag", 32'(link_fail), 32'd1);
    check_val("prbs_fail_retry", 32'(retry_count), 32'(MAX_RETRIES));
    drive(0, 1, 0, 1, 7'd0);
    repeat (2) tick();

    // Saturation at 16'hFFFF
    drive(1, 1, 0, 1, 7'd127);
    n = 0; prev = int'(state);
    while (!(prev == S_PRBS && int'(state) != S_PRBS) && n < 5000) begin
      prev = int'(state);
      tick(); n++;
    end
    check_val("prbs_saturate", 32'(prbs_err_total), 32'hFFFF);
`endif

    // Enable dropped mid-test
    drive(1, 1, 0, 1, 7'd127);
    for (int i = 0; i < 5000 && int'(state) != MID; i++) tick();
    check_val("mid_reach", 32'(state), 32'(MID));
    repeat (10) tick();
    drive(0, 1, 0, 1, 7'd127);
    tick();
    check_val("en_drop", 32'(dut_bundle()), 32'(RST_BUNDLE));
    tick();

    // Lock never arrives
    drive(1, 0, 0, 1, 7'd0);
    n = 0; cnt = 0;
    while (!link_fail && n < 20000) begin
      tick(); n++;
      if (!link_fail && phy_rx_rst) cnt++;
    end
    check_val("nolock_fail_time", 32'(n - 1), 32'((MAX_RETRIES + 1) * (RESET_HOLD + LOCK_TIMEOUT)));
    check_val("nolock_rst_cycles", 32'(cnt), 32'((MAX_RETRIES + 1) * RESET_HOLD));
    check_val("nolock_retry", 32'(retry_count), 32'(MAX_RETRIES));
    drive(1, 1, 0, 1, 7'd0);
    repeat (5) tick();
    check_val("fail_sticky", 32'({link_fail, phy_rx_rst}), 32'b11);
    drive(0, 1, 0, 1, 7'd0);
    tick();
    check_val("fail_clear", 32'({link_fail, state}), 32'd0);

    // Asynchronous reset mid-run
    drive(1, 1, 0, 1, 7'd0);
    repeat (30) tick();
    @(posedge clk_tb);
    model_step();
    #3 rx_rst_tb = 1'b0;
    #1;
    check_val("async_rst", 32'(dut_bundle()), 32'(RST_BUNDLE));
    model_reset();
    @(negedge clk_tb) rx_rst_tb = 1'b1;
    tick();
    check_val("post_rst_state", 32'(state), 32'(S_RESET));

    // Randomized segments
    for (int seg = 0; seg < 25; seg++) begin
      int mode, len;
      mode = int'($urandom_range(0, 4));
      len  = int'($urandom_range(100, 1200));
      for (int i = 0; i < len; i++) begin
        logic en, lk, hb, st;
        logic [6:0] err;
        en = 1'b1; lk = 1'b1; hb = 1'b0; st = 1'b1; err = 7'd0;
        case (mode)
          1: err = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
          2: begin
            lk = ($urandom_range(0, 299) != 0);
            hb = ($urandom_range(0, 499) == 0);
          end
          3: st = ($urandom_range(0, 19) != 0);
          4: en = ($urandom_range(0, 199) != 0);
          default: ;
        endcase
        drive(en, lk, hb, st, err);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/eth_phy_link_ctrl.md
Name: eth_phy_link_ctrl

Overview:
Link bring-up and supervision controller for the 10G PHY (eth_phy_10g) receive path. It pulses the PHY rx reset, waits for block lock, and optionally runs a PRBS31 loop self-test using the PHY error counter. It then declares link up and supervises lock/high-BER, retrying up to a limit before latching failure. It sits beside the PHY in the rx clock domain and drives the PHY's rx reset and cfg_*_prbs31_enable inputs.

Parameters:
RESET_HOLD, 16, cycles rx PHY reset is held asserted (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before a retry
PRBS_CYCLES, 1024, PRBS31 test window length in cycles
ERR_THRESH, 16, accumulated PRBS errors at or above which the test fails
STABLE_CYCLES, 64, consecutive cycles of lock && !high_ber && status needed for link_up
MAX_RETRIES, 3, retries before FAIL (retry_count width = $clog2(MAX_RETRIES+1))

Ports:
clk  in  1  clock, same as PHY rx_clk
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run bring-up, 0 = return to IDLE
rx_block_lock  in  1  from PHY
rx_high_ber  in  1  from PHY
rx_status  in  1  from PHY
rx_error_count  in  7  per-cycle PRBS error count from PHY
phy_rx_rst  out  1  active-high reset to PHY rx_rst
cfg_tx_prbs31_enable  out  1  to PHY
cfg_rx_prbs31_enable  out  1  to PHY
link_up  out  1  registered; 1 only in UP
link_fail  out  1  registered; 1 only in FAIL
retry_count  out  2  retries consumed (default width)
prbs_err_total  out  16  saturating error sum of last PRBS window
state  out  3  current state encoding

Behaviour:
- Reset (rst_n=0, async): state=IDLE, phy_rx_rst=1, prbs enables=0, link_up=0, link_fail=0, retry_count=0, prbs_err_total=0, timer=0.
- All outputs registered; state changes take effect on outputs the same edge.
- IDLE (0): phy_rx_rst=1. enable=1 -> RESET, timer=RESET_HOLD-1, retry_count=0.
- RESET (1): phy_rx_rst=1; timer==0 -> WAIT_LOCK, timer=LOCK_TIMEOUT-1, phy_rx_rst=0.
- WAIT_LOCK (2): rx_block_lock=1 -> PRBS_TEST (timer=PRBS_CYCLES-1, prbs enables=1, prbs_err_total cleared). Timer==0 without lock -> retry.
- PRBS_TEST (3): each cycle prbs_err_total += rx_error_count, saturating at 16'hFFFF. At timer==0: enables=0; if total (including final cycle's count) >= ERR_THRESH -> retry, else WAIT_STABLE with timer=STABLE_CYCLES-1. Loss of lock mid-test -> retry immediately.
- WAIT_STABLE (4): any cycle with !(lock && !high_ber && status) reloads timer; timer==0 with good condition -> UP.
- UP (5): link_up=1. rx_high_ber=1 or rx_block_lock=0 -> retry (link_up drops next edge).
- Retry: if retry_count==MAX_RETRIES -> FAIL, else retry_count++, -> RESET, timer=RESET_HOLD-1, prbs enables=0.
- FAIL (6): link_fail=1, phy_rx_rst=1, sticky until enable=0 (-> IDLE) or reset.
- enable=0 in any state -> IDLE next edge (highest priority over every other transition); prbs enables cleared.
- Successful UP does not clear retry_count; only IDLE entry/enable rising does.
- Timer is a single shared down-counter, width $clog2 of max(RESET_HOLD, LOCK_TIMEOUT, PRBS_CYCLES, STABLE_CYCLES); never wraps below 0.

Optional Feature:
LINK_CTRL_PRBS_EN: defined -> PRBS_TEST state present as above. Undefined -> WAIT_LOCK goes straight to WAIT_STABLE on lock, cfg_*_prbs31_enable tied 0, prbs_err_total tied 0, ERR_THRESH/PRBS_CYCLES unused; encoding 3 never appears.

Decomposition:
- Package eth_phy_link_ctrl_pkg: state encoding constants (IDLE..FAIL, 3 bits), PRBS_ERR_W=16, ERR_CNT_W=7.
- Sub-module link_ctrl_timer: loadable down-counter with load/value/zero flag; instantiated once.

Test Plan:
- Lock at cycle 20 after RESET, zero PRBS errors, clean status -> link_up=1 at 16+1+1024+64 cycles after enable (±1 documented), retry_count=0.
- rx_error_count=1 every cycle of the PRBS window -> prbs_err_total=1024, retry; persistent -> link_fail=1 after 3 retries, retry_count=3.
- Lock never asserted -> RESET/WAIT_LOCK cycle 4 times, FAIL after 4*(16+4096) cycles; phy_rx_rst high during each RESET.
- In UP, pulse rx_high_ber for 1 cycle -> link_up=0 next edge, phy_rx_rst=1 for 16 cycles, retry_count increments.
- rx_error_count=127 every cycle -> prbs_err_total saturates at 16'hFFFF, not wrap.
- enable deasserted mid-PRBS_TEST; separately rst_n pulsed low -> IDLE, prbs enables 0 next edge (async for rst_n), all outputs at reset values.
